// File: rtl/dot_mover_bram_multi_pkg.sv
// Shared definitions for the multi-lane BRAM dot-product mover: FSM states,
// pipeline constants and the accumulator sizing rule.
package dot_mover_bram_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DRAIN_LEN = 3;
  localparam int RD_LAT    = 1;

  // Accumulator wide enough for the full product sum, never wider than 64 bits.
  function automatic int acc_width(input int in_w, input int cnt_w);
    return ((2 * in_w + cnt_w) > 64) ? 64 : (2 * in_w + cnt_w);
  endfunction

endpackage

// File: rtl/dot_mover_bram_multi_if.sv
// BRAM bank bus: node/weight/bias read ports and the result write port.
interface dot_mover_bram_multi_if #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 32,
  parameter int OUT_WIDTH = 32
);
  logic [AWIDTH-1:0]    addr_b0, addr_b1, addr_b2, addr_b3;
  logic                 ce_b0, ce_b1, ce_b2, ce_b3, we_b3;
  logic [DWIDTH-1:0]    q_b0, q_b1, q_b2;
  logic [OUT_WIDTH-1:0] d_b3;

  modport master (
    output addr_b0, addr_b1, addr_b2, addr_b3,
    output ce_b0, ce_b1, ce_b2, ce_b3, we_b3, d_b3,
    input  q_b0, q_b1, q_b2
  );

  modport slave (
    input  addr_b0, addr_b1, addr_b2, addr_b3,
    input  ce_b0, ce_b1, ce_b2, ce_b3, we_b3, d_b3,
    output q_b0, q_b1, q_b2
  );
endinterface

// File: rtl/dot_mover_bram_multi_dot_lane_mac.sv
// One lane: signed multiply register, wrapping accumulator, bias add,
// optional ReLU and saturation into a registered result.
module dot_lane_mac
  import dot_mover_bram_multi_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 16,
  parameter int ACC_WIDTH     = 63,
  parameter int OUT_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_clr,
  input  logic                            i_vld,
  input  logic                            i_bias_en,
  input  logic                            i_load,
  input  logic                            i_relu,
  input  logic signed [IN_DATA_WIDTH-1:0] i_node,
  input  logic signed [IN_DATA_WIDTH-1:0] i_wgt,
  input  logic signed [IN_DATA_WIDTH-1:0] i_bias,
  output logic signed [OUT_WIDTH-1:0]     o_res
);

  localparam int PW = 2 * IN_DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]            r_prod;
  logic                            r_prod_vld;
  logic signed [ACC_WIDTH-1:0]     r_acc;
  logic signed [IN_DATA_WIDTH-1:0] r_bias;
  logic signed [OUT_WIDTH-1:0]     r_res;
  logic signed [SW-1:0]            w_sum;

  function automatic logic signed [OUT_WIDTH-1:0] relu_sat(input logic signed [SW-1:0] s,
                                                          input logic relu);
    if (relu && s[SW-1]) return '0;
    else if (s > MAXV)   return MAXV[OUT_WIDTH-1:0];
    else if (s < MINV)   return MINV[OUT_WIDTH-1:0];
    else                 return s[OUT_WIDTH-1:0];
  endfunction

  // One guard bit keeps the bias add from wrapping before saturation.
  assign w_sum = {r_acc[ACC_WIDTH-1], r_acc}
               + {{(SW-IN_DATA_WIDTH){r_bias[IN_DATA_WIDTH-1]}}, r_bias};
  assign o_res = r_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_bias     <= '0;
      r_res      <= '0;
    end else begin
      r_prod <= i_node * i_wgt;
      if (i_clr) begin
        r_acc      <= '0;
        r_prod_vld <= 1'b0;
      end else begin
        r_prod_vld <= i_vld;
        if (r_prod_vld) r_acc <= r_acc + {{(ACC_WIDTH-PW){r_prod[PW-1]}}, r_prod};
      end
      if (i_bias_en) r_bias <= i_bias;
      if (i_load)    r_res  <= relu_sat(w_sum, i_relu);
    end
  end

endmodule

// File: rtl/dot_mover_bram_multi.sv
// Streams packed node/weight words, runs NUM_CORE dot-product lanes with bias
// and optional ReLU, then writes one saturated result per lane to BRAM.
module dot_mover_bram_multi
  import dot_mover_bram_multi_pkg::*;
#(
  parameter int CNT_BIT       = 31,
  parameter int AWIDTH        = 12,
  parameter int MEM_SIZE      = 4096,
  parameter int IN_DATA_WIDTH = 16,
  parameter int NUM_CORE      = 2,
  parameter int DWIDTH        = IN_DATA_WIDTH * NUM_CORE,
  parameter int ACC_WIDTH     = acc_width(IN_DATA_WIDTH, CNT_BIT),
  parameter int OUT_WIDTH     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_run,
  input  logic [CNT_BIT-1:0]            i_num_cnt,
  input  logic                          i_relu,
  output logic                          o_idle,
  output logic                          o_read,
  output logic                          o_write,
  output logic                          o_done,
  dot_mover_bram_multi_if.master        bram,
  output logic [NUM_CORE*OUT_WIDTH-1:0] o_result
);

  localparam int LW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam logic [CNT_BIT-1:0] MEM_C = CNT_BIT'(MEM_SIZE);

  state_e                    r_state;
  logic [AWIDTH:0]           r_n, r_cnt;
  logic [AWIDTH-1:0]         r_addr_rd, r_addr_wr;
  logic                      r_relu, r_clr, r_ce_rd, r_ce_bias, r_we, r_idle, r_done;
  logic [RD_LAT-1:0]         r_rd_pipe, r_bias_pipe;
  logic [AWIDTH:0]           w_n_sat;
  logic                      w_load;
  logic [OUT_WIDTH-1:0]      w_lane_res [NUM_CORE];

  assign w_n_sat = (i_num_cnt > MEM_C) ? (AWIDTH+1)'(MEM_SIZE) : i_num_cnt[AWIDTH:0];
  assign w_load  = (r_state == ST_DRAIN) && (r_cnt == (AWIDTH+1)'(DRAIN_LEN - 1));

  assign bram.addr_b0 = r_addr_rd;
  assign bram.addr_b1 = r_addr_rd;
  assign bram.ce_b0   = r_ce_rd;
  assign bram.ce_b1   = r_ce_rd;
  assign bram.addr_b2 = '0;
  assign bram.ce_b2   = r_ce_bias;
  assign bram.addr_b3 = r_addr_wr;
  assign bram.ce_b3   = r_we;
  assign bram.we_b3   = r_we;
  assign bram.d_b3    = w_lane_res[r_addr_wr[LW-1:0]];

  assign o_idle  = r_idle;
  assign o_read  = r_ce_rd;
  assign o_write = r_we;
  assign o_done  = r_done;

  // Control FSM; the read-valid and bias-capture strobes follow the BRAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_cnt       <= '0;
      r_addr_rd   <= '0;
      r_addr_wr   <= '0;
      r_relu      <= 1'b0;
      r_clr       <= 1'b0;
      r_ce_rd     <= 1'b0;
      r_ce_bias   <= 1'b0;
      r_we        <= 1'b0;
      r_idle      <= 1'b1;
      r_done      <= 1'b0;
      r_rd_pipe   <= '0;
      r_bias_pipe <= '0;
    end else begin
      r_clr       <= 1'b0;
      r_ce_bias   <= 1'b0;
      r_rd_pipe   <= RD_LAT'({r_rd_pipe, r_ce_rd});
      r_bias_pipe <= RD_LAT'({r_bias_pipe, r_ce_bias});
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            r_n       <= w_n_sat;
            r_relu    <= i_relu;
            r_clr     <= 1'b1;
            r_ce_bias <= 1'b1;
            r_cnt     <= '0;
            r_addr_rd <= '0;
            r_idle    <= 1'b0;
            if (w_n_sat == '0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_RUN;
              r_ce_rd <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (r_cnt == r_n - (AWIDTH+1)'(1)) begin
            r_state <= ST_DRAIN;
            r_ce_rd <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt     <= r_cnt + (AWIDTH+1)'(1);
            r_addr_rd <= r_addr_rd + AWIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (w_load) begin
            r_state   <= ST_WRITE;
            r_we      <= 1'b1;
            r_addr_wr <= '0;
          end else begin
            r_cnt <= r_cnt + (AWIDTH+1)'(1);
          end
        end
        ST_WRITE: begin
          if (r_addr_wr == AWIDTH'(NUM_CORE - 1)) begin
            r_state <= ST_DONE;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_addr_wr <= r_addr_wr + AWIDTH'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ce_rd <= 1'b0;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CORE; c++) begin : g_lane
    dot_lane_mac #(
      .IN_DATA_WIDTH(IN_DATA_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .OUT_WIDTH    (OUT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (r_clr),
      .i_vld    (r_rd_pipe[RD_LAT-1]),
      .i_bias_en(r_bias_pipe[RD_LAT-1]),
      .i_load   (w_load),
      .i_relu   (r_relu),
      .i_node   (bram.q_b0[c*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
      .i_wgt    (bram.q_b1[c*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
      .i_bias   (bram.q_b2[c*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
      .o_res    (w_lane_res[c])
    );
    assign o_result[c*OUT_WIDTH +: OUT_WIDTH] = w_lane_res[c];
  end

endmodule

// File: tb/tb_dot_mover_bram_multi.sv
// Randomised scoreboard bench: stimulus pushes reference-model results, a
// negedge monitor pops and compares on every o_done and polices the BRAM bus.
module tb_dot_mover_bram_multi;

  localparam int NC = 2;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            i_run, i_relu;
  logic [30:0]     i_num_cnt;
  logic            o_idle, o_read, o_write, o_done;
  logic [NC*OW-1:0] o_result;

  dot_mover_bram_multi_if #(.AWIDTH(12), .DWIDTH(32), .OUT_WIDTH(OW)) bus ();

  dot_mover_bram_multi dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt), .i_relu(i_relu),
    .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
    .bram(bus), .o_result(o_result)
  );

  always #5 clk = ~clk;

  logic [31:0] node_mem [4096];
  logic [31:0] wgt_mem  [4096];
  logic [31:0] bias_word;

  // Synchronous-read BRAM models, one cycle of latency.
  always @(posedge clk) begin
    if (bus.ce_b0) bus.q_b0 <= node_mem[bus.addr_b0];
    if (bus.ce_b1) bus.q_b1 <= wgt_mem[bus.addr_b1];
    if (bus.ce_b2) bus.q_b2 <= bias_word;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    int          c0;
    logic [63:0] res;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dot product from plain integer arithmetic over the BRAM image.
  function automatic longint ref_lane(input int n, input int c, input bit relu);
    longint s = 0;
    logic signed [15:0] a, b, bb;
    for (int i = 0; i < n; i++) begin
      a = node_mem[i][c*16 +: 16];
      b = wgt_mem[i][c*16 +: 16];
      s += longint'(a) * longint'(b);
    end
    bb = bias_word[c*16 +: 16];
    s += longint'(bb);
    if (relu && s < 0) s = 0;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  bit          post_done = 1'b0;
  logic [31:0] wr_seen [NC];

  // Monitor: reset-state checks, write capture, and scoreboard pops on o_done.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_flags", 64'({o_idle, o_read, o_write, o_done, bus.ce_b0, bus.ce_b1,
                               bus.ce_b2, bus.ce_b3, bus.we_b3}), 64'h100);
      check("reset_addr", 64'({bus.addr_b0, bus.addr_b1, bus.addr_b2, bus.addr_b3}), 64'h0);
      check("reset_result", o_result, 64'h0);
      rd_cnt    = 0;
      wr_cnt    = 0;
      post_done = 1'b0;
    end else begin
      if (post_done) begin
        check("idle_after_done", 64'(o_idle), 64'h1);
        post_done = 1'b0;
      end
      if (bus.ce_b0) rd_cnt++;
      if (bus.we_b3) begin
        if (exp_q.size() == 0) check("stray_write", 64'(bus.addr_b3), 64'hFFFF);
        else if (bus.addr_b3 < 12'(NC)) wr_seen[bus.addr_b3[0]] = bus.d_b3;
        wr_cnt++;
      end
      if (o_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'h1, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", o_result, e.res);
          check("done_latency", 64'(cyc - e.c0), 64'(e.n + 3 + NC));
          check("read_count", 64'(rd_cnt), 64'(e.n));
          check("write_count", 64'(wr_cnt), 64'(NC));
          for (int c = 0; c < NC; c++)
            check("bram_word", 64'(wr_seen[c]), 64'(e.res[c*OW +: OW]));
        end
        rd_cnt    = 0;
        wr_cnt    = 0;
        post_done = 1'b1;
      end else if (exp_q.size() != 0 && cyc > exp_q[0].c0 + exp_q[0].n + 3 + NC + 8) begin
        check("done_timeout", 64'(cyc - exp_q[0].c0), 64'(exp_q[0].n + 3 + NC));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 50 && !o_idle; k++) @(negedge clk);
  endtask

  // Cycle k is the period ending on edge k, edge 0 being the one that accepts i_run.
  task automatic start(input int nreq, input bit relu, input bit poke_run, input bit poke_done);
    exp_t e;
    longint v;
    int n;
    n = (nreq > 4096) ? 4096 : nreq;
    e.n = n;
    for (int c = 0; c < NC; c++) begin
      v = ref_lane(n, c, relu);
      e.res[c*OW +: OW] = v[OW-1:0];
    end
    @(negedge clk);
    wait_idle();
    i_num_cnt = 31'(nreq);
    i_relu    = relu;
    i_run     = 1'b1;
    @(posedge clk);
    #1;
    e.c0 = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    i_run     = 1'b0;
    i_relu    = ~relu;
    i_num_cnt = 31'($urandom_range(0, 3));
    if (poke_run && n > 2) begin
      @(negedge clk); i_run = 1'b1;
      @(negedge clk); i_run = 1'b0;
    end
    if (poke_done) begin
      while (cyc < e.c0 + n + 3 + NC) @(negedge clk);
      i_run = 1'b1;
      @(negedge clk); i_run = 1'b0;
    end
    while (exp_q.size() != 0) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic fill(input int n, input logic [31:0] nd, input logic [31:0] wt, input bit rnd);
    for (int i = 0; i < n; i++) begin
      node_mem[i] = rnd ? $urandom : nd;
      wgt_mem[i]  = rnd ? $urandom : wt;
    end
  endtask

  initial begin
    int c0;
    i_run = 1'b0; i_relu = 1'b0; i_num_cnt = '0; bias_word = '0;
    for (int i = 0; i < 4096; i++) begin node_mem[i] = '0; wgt_mem[i] = '0; end
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    fill(4, 32'h0001_0001, 32'h0002_0002, 1'b0);
    bias_word = {16'hFFFB, 16'h0003};
    start(4, 1'b0, 1'b0, 1'b0);
    bias_word = {16'hFFEC, 16'h0003};
    start(4, 1'b1, 1'b0, 1'b0);
    start(4, 1'b0, 1'b1, 1'b1);

    bias_word = {16'hFFF7, 16'h0007};
    start(0, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(0, 40);
      fill(n, '0, '0, 1'b1);
      bias_word = $urandom;
      start(n, 1'($urandom_range(0, 1)), (r % 3) == 0, (r % 4) == 1);
    end

    // Abort an N=100 run in its fifth cycle; no result write may appear.
    fill(100, '0, '0, 1'b1);
    @(negedge clk);
    wait_idle();
    i_num_cnt = 31'd100; i_relu = 1'b0; i_run = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk) i_run = 1'b0;
    while (cyc < c0 + 4) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (120) @(negedge clk);
    fill(4, 32'h0001_0001, 32'h0002_0002, 1'b0);
    bias_word = {16'hFFFB, 16'h0003};
    start(4, 1'b0, 1'b0, 1'b0);

    fill(4096, 32'h8000_8000, 32'h8000_8000, 1'b0);
    bias_word = '0;
    start(4096, 1'b0, 1'b0, 1'b0);
    fill(4096, '0, '0, 1'b1);
    bias_word = $urandom;
    start(5000, 1'b1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
